// File: rtl/led_arb_pkg.sv
// Shared constants, state encoding and a constant clog2 helper for the
// LED blink-code arbiter.
package led_arb_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // Width of one requester's blink-count field.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_ON   = S_ON,
    ST_OFF  = S_OFF,
    ST_GAP  = S_GAP
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV cycles while run is high,
// held at zero while run is low so each phase starts on a fresh tick period.
module tick_gen
  import led_arb_pkg::*;
#(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int PW = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (!run || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing one LED between NUM_REQ requesters; the granted
// requester's blink code is played with prescaled on/off/gap timing.
module led_blink_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TICK_DIV  = 5000000,
  parameter int ON_TICKS  = 3,
  parameter int OFF_TICKS = 3,
  parameter int GAP_TICKS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [CNT_W*NUM_REQ-1:0] count,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     led,
  output logic                     busy
);

  localparam int IDX_W  = clog2(NUM_REQ);
  localparam int MAX_OF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_PH = (MAX_OF > GAP_TICKS) ? MAX_OF : GAP_TICKS;
  localparam int PH_W   = (clog2(MAX_PH) < 1) ? 1 : clog2(MAX_PH);

  localparam logic [PH_W-1:0]  ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]  OFF_LAST = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0]  GAP_LAST = PH_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                led_q, led_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [PH_W-1:0]     phase_q, phase_d;

  logic                tick;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_REQ-1:0]  win_oh;
  logic [CNT_W-1:0]    cnt_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign cnt_arr[g] = count[g*CNT_W +: CNT_W];
  end

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (state_q != ST_IDLE),
    .tick  (tick)
  );

  // Scan from farthest to nearest so the nearest set bit after last_q wins.
  always_comb begin
    cand    = '0;
    win_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (req[cand]) win_idx = cand;
    end
  end

  assign win_oh = NUM_REQ'(1) << win_idx;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    led_d   = led_q;
    last_d  = last_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    if (tick) phase_d = phase_q + PH_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = win_oh;
          last_d  = win_idx;
          rem_d   = cnt_arr[win_idx];
          if (cnt_arr[win_idx] != '0) begin
            state_d = ST_ON;
            led_d   = 1'b1;
          end else begin
            state_d = ST_GAP;
            led_d   = 1'b0;
          end
        end
      end
      ST_ON: begin
        led_d = 1'b1;
        if (tick && (phase_q == ON_LAST)) begin
          led_d   = 1'b0;
          if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        led_d = 1'b0;
        if (tick && (phase_q == OFF_LAST)) begin
          if (rem_q == '0) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_ON;
            led_d   = 1'b1;
          end
        end
      end
      ST_GAP: begin
        led_d = 1'b0;
        if (tick && (phase_q == GAP_LAST)) begin
          done_d  = grant_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Each phase measures its length from its own entry.
    if (state_d != state_q) phase_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      led_q   <= 1'b0;
      last_q  <= IDX_LAST;
      rem_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      led_q   <= led_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign led   = led_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter: table of single grants, directed corner
// sequences and random traffic, all shadowed by a timeline reference model.
module tb_led_blink_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TD      = 4;
  localparam int ON_T    = 2;
  localparam int OFF_T   = 1;
  localparam int GAP_T   = 3;
  localparam int BLINK   = (ON_T + OFF_T) * TD;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req   = '0;
  logic [15:0] count = '0;
  logic [3:0]  grant, done;
  logic        led, busy;

  int n_vec = 0;
  int n_err = 0;

  led_blink_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .TICK_DIV  (TD),
    .ON_TICKS  (ON_T),
    .OFF_TICKS (OFF_T),
    .GAP_TICKS (GAP_T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .count (count),
    .grant (grant),
    .done  (done),
    .led   (led),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a granted sequence is a timeline of known length; the
  // LED pattern and done pulse follow from the cycle offset into it.
  bit         m_ok   = 1'b0;
  bit         m_act  = 1'b0;
  int         m_t    = 0;
  int         m_len  = 0;
  int         m_c    = 0;
  int         m_win  = 0;
  int         m_last = NUM_REQ - 1;
  bit         m_found;
  logic [3:0] e_grant = '0, e_done = '0;
  logic       e_led = 1'b0, e_busy = 1'b0;

  always @(posedge clk) begin
    e_done = '0;
    if (reset) begin
      m_act  = 1'b0;
      m_last = NUM_REQ - 1;
    end else if (!m_act) begin
      if (req != '0) begin
        m_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (!m_found && req[(m_last + k) % NUM_REQ]) begin
            m_win   = (m_last + k) % NUM_REQ;
            m_found = 1'b1;
          end
        end
        m_last = m_win;
        m_act  = 1'b1;
        m_t    = 0;
        m_c    = int'((count >> (4 * m_win)) & 16'hF);
        m_len  = m_c * BLINK + GAP_T * TD;
      end
    end else begin
      m_t++;
      if (m_t == m_len) begin
        m_act  = 1'b0;
        e_done = 4'(1 << m_win);
      end
    end
    e_grant = m_act ? 4'(1 << m_win) : 4'b0;
    e_led   = m_act && (m_t < m_c * BLINK) && ((m_t % BLINK) < ON_T * TD);
    e_busy  = m_act;
    m_ok    = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock, then compare every output against the model.
  task automatic step();
    @(negedge clk);
    if (m_ok) check("cycle_model {grant,done,led,busy}",
                    {22'b0, grant, done, led, busy},
                    {22'b0, e_grant, e_done, e_led, e_busy});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int idle);
    idle = 0;
    while (grant == '0 && idle < 50) begin
      idle++;
      step();
    end
  endtask

  task automatic measure(input int mod_at, output int len, output int high,
                         output logic [3:0] dn);
    len  = 0;
    high = 0;
    while (grant != '0 && len < 400) begin
      if (len == mod_at) begin
        req   = '0;
        count = 16'h0007;
      end
      len++;
      if (led) high++;
      step();
    end
    dn = done;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] count;
    logic [3:0]  exp_grant;
    int          exp_len;
    int          exp_high;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int idle, len, high;
    logic [3:0] dn;

    tbl[0] = '{4'b0001, 16'h0003, 4'b0001, 48,  24};
    tbl[1] = '{4'b0001, 16'h0000, 4'b0001, 12,  0};
    tbl[2] = '{4'b0010, 16'h0020, 4'b0010, 36,  16};
    tbl[3] = '{4'b0011, 16'h0011, 4'b0001, 24,  8};
    tbl[4] = '{4'b1100, 16'hF400, 4'b0100, 60,  32};
    tbl[5] = '{4'b1000, 16'hF000, 4'b1000, 192, 120};
    tbl[6] = '{4'b1001, 16'h1002, 4'b0001, 36,  16};

    step();
    step();
    reset = 1'b0;
    check("reset_grant", {28'b0, grant}, 32'd0);
    check("reset_done",  {28'b0, done},  32'd0);
    check("reset_led",   {31'b0, led},   32'd0);
    check("reset_busy",  {31'b0, busy},  32'd0);

    for (int v = 0; v < 7; v++) begin
      count = tbl[v].count;
      req   = tbl[v].req;
      wait_grant(idle);
      check($sformatf("tbl%0d_latency", v), idle, 1);
      check($sformatf("tbl%0d_grant", v), {28'b0, grant}, {28'b0, tbl[v].exp_grant});
      req = '0;
      measure(-1, len, high, dn);
      check($sformatf("tbl%0d_len", v), len, tbl[v].exp_len);
      check($sformatf("tbl%0d_led_high", v), high, tbl[v].exp_high);
      check($sformatf("tbl%0d_done", v), {28'b0, dn}, {28'b0, tbl[v].exp_grant});
    end

    // Round robin with every requester held.
    do_reset();
    req   = 4'b1111;
    count = 16'h1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(idle);
      check($sformatf("rr%0d_idle", g), idle, 1);
      check($sformatf("rr%0d_grant", g), {28'b0, grant}, 32'(1 << (g % 4)));
      if (g == 4) req = '0;
      measure(-1, len, high, dn);
      check($sformatf("rr%0d_len", g), len, 24);
      check($sformatf("rr%0d_done", g), {28'b0, dn}, 32'(1 << (g % 4)));
    end

    // Reset in the middle of an ON phase.
    do_reset();
    req   = 4'b0001;
    count = 16'h0003;
    wait_grant(idle);
    req = '0;
    repeat (5) step();
    reset = 1'b1;
    step();
    check("abort_led",   {31'b0, led},   32'd0);
    check("abort_grant", {28'b0, grant}, 32'd0);
    check("abort_busy",  {31'b0, busy},  32'd0);
    check("abort_done",  {28'b0, done},  32'd0);
    reset = 1'b0;
    repeat (3) step();
    req   = 4'b0011;
    count = 16'h0011;
    wait_grant(idle);
    check("post_abort_grant", {28'b0, grant}, 32'd1);
    req = '0;
    measure(-1, len, high, dn);
    check("post_abort_len",  len, 24);
    check("post_abort_done", {28'b0, dn}, 32'd1);

    // Request dropped and count changed after the grant.
    req   = 4'b0001;
    count = 16'h0003;
    wait_grant(idle);
    measure(10, len, high, dn);
    check("latched_len",  len, 48);
    check("latched_high", high, 24);
    check("latched_done", {28'b0, dn}, 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < 4; k++)
          count[4*k +: 4] = 4'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 15 : 3));
      end
      reset = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
